// File: rtl/hawk_att_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : hawk_att_lookup
//  Description : Translates a host physical address into an ATT entry lookup.
//                It fetches the 64-byte ATT block holding the entry over an
//                AXI read, decodes the entry and returns the translation.
//                One lookup is outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module hawk_att_lookup #(
    parameter logic [63:0] ATT_BASE      = 64'hFFF6100000,
    parameter logic [63:0] HPPA_BASE     = 64'h80000000,
    parameter int unsigned ATT_ENTRY_CNT = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    // CPU lookup request
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [47:0]  req_hppa,
    // AXI read address channel (single 64B beat, arlen=0, arsize=6)
    output logic         arvalid,
    input  logic         arready,
    output logic [63:0]  araddr,
    // AXI read data channel
    input  logic         rvalid,
    output logic         rready,
    input  logic         rlast,
    input  logic [511:0] rdata,
    input  logic [1:0]   rresp,
    // Translation result
    output logic         out_valid,
    input  logic         out_ready,
    output logic [47:0]  out_ppa,
    output logic [1:0]   out_sts,
    output logic         out_allow,
    output logic         out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } state_t;

    // Entry status meaning "uncompressed, access allowed".
    localparam logic [1:0] STS_UNCOMP = 2'b01;
    localparam logic [63:0] BLK_MASK  = ~64'h3F;

    state_t       state_q;
    logic         arvalid_q;
    logic         rready_q;
    logic         out_valid_q;
    logic [63:0]  araddr_q;
    logic [2:0]   slot_q;
    logic         first_q;
    logic [49:0]  entry_q;
    logic [1:0]   rresp_q;
    logic [47:0]  out_ppa_q;
    logic [1:0]   out_sts_q;
    logic         out_allow_q;
    logic         out_err_q;

    // Request address decode: entry index, range check and block address.
    logic [63:0]  hppa_ext;
    logic         below_base;
    logic [63:0]  diff;
    logic [63:0]  idx_d;
    logic         oob_d;
    logic [63:0]  entry_addr;
    logic [63:0]  araddr_d;

    assign hppa_ext   = {16'd0, req_hppa};
    assign below_base = (hppa_ext < HPPA_BASE);
    assign diff       = hppa_ext - HPPA_BASE;
    assign idx_d      = diff >> 12;
    assign oob_d      = below_base || (idx_d >= 64'(ATT_ENTRY_CNT));
    assign entry_addr = ATT_BASE + (idx_d << 3);
    assign araddr_d   = entry_addr & BLK_MASK;

    // Entry selection: the first beat supplies the entry directly; if the
    // closing beat is a later one, the value captured from the first is used.
    logic [8:0]   bit_off;
    logic [49:0]  beat_entry;
    logic [49:0]  entry_d;
    logic [1:0]   resp_d;
    logic [1:0]   sts_d;

    assign bit_off    = {slot_q, 6'd0};
    assign beat_entry = rdata[bit_off +: 50];
    assign entry_d    = first_q ? beat_entry : entry_q;
    assign resp_d     = first_q ? rresp : rresp_q;
    assign sts_d      = entry_d[1:0];

    // Request acceptance is gated by reset so nothing is taken while held.
    assign req_ready = (state_q == IDLE) && !rst_i;
    assign arvalid   = arvalid_q;
    assign araddr    = araddr_q;
    assign rready    = rready_q;
    assign out_valid = out_valid_q;
    assign out_ppa   = out_ppa_q;
    assign out_sts   = out_sts_q;
    assign out_allow = out_allow_q;
    assign out_err   = out_err_q;

    // Lookup FSM: all handshake outputs and results are registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            out_valid_q <= 1'b0;
            araddr_q    <= 64'd0;
            slot_q      <= 3'd0;
            first_q     <= 1'b0;
            entry_q     <= 50'd0;
            rresp_q     <= 2'd0;
            out_ppa_q   <= 48'd0;
            out_sts_q   <= 2'd0;
            out_allow_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (oob_d) begin
                            // No memory access for an address outside the table.
                            state_q     <= RESP;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                            out_allow_q <= 1'b0;
                            out_sts_q   <= 2'd0;
                            out_ppa_q   <= 48'd0;
                        end else begin
                            state_q   <= AR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= araddr_d;
                            slot_q    <= idx_d[2:0];
                            first_q   <= 1'b1;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (rvalid && rready_q) begin
                        first_q <= 1'b0;
                        if (first_q) begin
                            entry_q <= beat_entry;
                            rresp_q <= rresp;
                        end
                        if (rlast) begin
                            rready_q    <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= RESP;
                            if (resp_d != 2'b00) begin
                                out_err_q   <= 1'b1;
                                out_allow_q <= 1'b0;
                                out_sts_q   <= 2'd0;
                                out_ppa_q   <= 48'd0;
                            end else begin
                                out_err_q   <= 1'b0;
                                out_sts_q   <= sts_d;
                                out_ppa_q   <= entry_d[49:2];
                                out_allow_q <= (sts_d == STS_UNCOMP);
                            end
                        end
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hawk_att_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hawk_att_lookup
//  Description : Directed self-checking bench for hawk_att_lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hawk_att_lookup;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid;
    logic         req_ready;
    logic [47:0]  req_hppa;
    logic         arvalid;
    logic         arready;
    logic [63:0]  araddr;
    logic         rvalid;
    logic         rready;
    logic         rlast;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         out_valid;
    logic         out_ready;
    logic [47:0]  out_ppa;
    logic [1:0]   out_sts;
    logic         out_allow;
    logic         out_err;

    int n_tests = 0;
    int n_fail  = 0;

    hawk_att_lookup dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_hppa  (req_hppa),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rlast     (rlast),
        .rdata     (rdata),
        .rresp     (rresp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ppa   (out_ppa),
        .out_sts   (out_sts),
        .out_allow (out_allow),
        .out_err   (out_err)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [511:0] BG = {8{64'h0003_FFFF_FFFF_FFFE}};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] place(input int slot, input logic [63:0] e);
        logic [511:0] r;
        r = BG;
        r[slot*64 +: 64] = e;
        return r;
    endfunction

    task automatic do_req(input logic [47:0] hppa);
        req_valid = 1'b1;
        req_hppa  = hppa;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ar_accept();
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic beat(input logic [511:0] d, input logic [1:0] resp, input logic last);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic out_accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [47:0] ppa, input logic [1:0] sts,
                           input logic allow, input logic err);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".ppa"},   64'(out_ppa),   64'(ppa));
        chk({tag, ".sts"},   64'(out_sts),   64'(sts));
        chk({tag, ".allow"}, 64'(out_allow), 64'(allow));
        chk({tag, ".err"},   64'(out_err),   64'(err));
    endtask

    logic [47:0] s_ppa;
    logic [1:0]  s_sts;
    logic        s_allow;
    logic        s_err;
    logic [63:0] s_addr;

    initial begin
        rst_i = 1'b1; req_valid = 1'b0; req_hppa = '0; arready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00; out_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.arvalid",   64'(arvalid),   64'd0);
        chk("rst.rready",    64'(rready),    64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.araddr",    araddr,         64'd0);
        chk("rst.out_ppa",   64'(out_ppa),   64'd0);
        chk("rst.out_err",   64'(out_err),   64'd0);
        rst_i = 1'b0;
        tick();
        chk("rel.req_ready", 64'(req_ready), 64'd1);

        // Hit, slot 3, sts=01
        do_req(48'h0000_8000_3000);
        chk("hit.arvalid",   64'(arvalid),   64'd1);
        chk("hit.araddr",    araddr,         64'hFF_F610_0000);
        chk("hit.req_ready", 64'(req_ready), 64'd0);
        ar_accept();
        chk("hit.arvalid_drop", 64'(arvalid), 64'd0);
        chk("hit.rready",    64'(rready),    64'd1);
        beat(place(3, {14'h2AAA, 48'h1234_5678_9ABC, 2'b01}), 2'b00, 1'b1);
        chk("hit.rready_drop", 64'(rready), 64'd0);
        chk_out("hit", 48'h1234_5678_9ABC, 2'b01, 1'b1, 1'b0);
        out_accept();
        chk("hit.out_valid_drop", 64'(out_valid), 64'd0);
        chk("hit.req_ready_back", 64'(req_ready), 64'd1);

        // Second block, slot 2, sts=10, two beats (second discarded)
        do_req(48'h0000_8000_A000);
        chk("blk2.araddr", araddr, 64'hFF_F610_0040);
        ar_accept();
        beat(place(2, {14'h0, 48'hABCD_EF01_2345, 2'b10}), 2'b00, 1'b0);
        chk("blk2.out_valid_early", 64'(out_valid), 64'd0);
        beat(place(2, {14'h0, 48'h1111_1111_1111, 2'b01}), 2'b00, 1'b1);
        chk_out("blk2", 48'hABCD_EF01_2345, 2'b10, 1'b0, 1'b0);
        out_accept();

        // Last valid entry (idx 15): block 0x...40, slot 7
        do_req(48'h0000_8000_F000);
        chk("idx15.araddr", araddr, 64'hFF_F610_0040);
        ar_accept();
        beat(place(7, {14'h0, 48'h0000_0000_0FED, 2'b01}), 2'b00, 1'b1);
        chk_out("idx15", 48'h0000_0000_0FED, 2'b01, 1'b1, 1'b0);
        out_accept();

        // Out of range: idx 16
        do_req(48'h0000_8001_0000);
        chk("oob16.arvalid", 64'(arvalid), 64'd0);
        chk_out("oob16", 48'd0, 2'b00, 1'b0, 1'b1);
        out_accept();

        // Out of range: below base
        do_req(48'h0000_7FFF_F000);
        chk("below.arvalid", 64'(arvalid), 64'd0);
        chk_out("below", 48'd0, 2'b00, 1'b0, 1'b1);
        out_accept();

        // Error response
        do_req(48'h0000_8000_3000);
        ar_accept();
        beat(place(3, {14'h0, 48'h1234_5678_9ABC, 2'b01}), 2'b10, 1'b1);
        chk_out("slverr", 48'd0, 2'b00, 1'b0, 1'b1);
        out_accept();

        // Backpressure on AR and on the result
        do_req(48'h0000_8000_3000);
        s_addr = araddr;
        chk("bp.araddr", s_addr, 64'hFF_F610_0000);
        req_valid = 1'b1;
        req_hppa  = 48'h0000_8000_5000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.ar_hold",  64'(arvalid),   64'd1);
            chk("bp.ar_addr",  araddr,         s_addr);
            chk("bp.ar_rrdy",  64'(req_ready), 64'd0);
        end
        ar_accept();
        beat(place(3, {14'h1555, 48'h0000_CAFE_F00D, 2'b01}), 2'b00, 1'b1);
        s_ppa = out_ppa; s_sts = out_sts; s_allow = out_allow; s_err = out_err;
        chk_out("bp", 48'h0000_CAFE_F00D, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp.out_valid", 64'(out_valid), 64'd1);
            chk("bp.out_ppa",   64'(out_ppa),   64'(s_ppa));
            chk("bp.out_sts",   64'(out_sts),   64'(s_sts));
            chk("bp.out_allow", 64'(out_allow), 64'(s_allow));
            chk("bp.out_err",   64'(out_err),   64'(s_err));
            chk("bp.out_rrdy",  64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        out_accept();
        chk("bp.done", 64'(out_valid), 64'd0);

        // Reset during R with read data pending
        do_req(48'h0000_8000_3000);
        ar_accept();
        chk("rstR.rready_pre", 64'(rready), 64'd1);
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = place(3, {14'h0, 48'h0000_0000_0BAD, 2'b01});
        rresp  = 2'b00;
        rst_i  = 1'b1;
        tick();
        chk("rstR.rready",    64'(rready),    64'd0);
        chk("rstR.out_valid", 64'(out_valid), 64'd0);
        chk("rstR.req_ready", 64'(req_ready), 64'd0);
        rst_i = 1'b0;
        tick();
        chk("rstR.req_ready_rel", 64'(req_ready), 64'd1);
        chk("rstR.out_valid_rel", 64'(out_valid), 64'd0);
        chk("rstR.rready_rel",    64'(rready),    64'd0);
        rvalid = 1'b0;
        rlast  = 1'b0;

        // Lookup after reset recovery
        do_req(48'h0000_8000_A000);
        chk("post.araddr", araddr, 64'hFF_F610_0040);
        ar_accept();
        beat(place(2, {14'h0, 48'h0000_0000_7777, 2'b01}), 2'b00, 1'b1);
        chk_out("post", 48'h0000_0000_7777, 2'b01, 1'b1, 1'b0);
        out_accept();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hawk_att_lookup.md
HAWK_ATT_LOOKUP -- requirements
Module: hawk_att_lookup

Interface
REQ-001 SHALL have parameter ATT_BASE, default 64'hFFF6100000, byte address of ATT entry 0.
REQ-002 SHALL have parameter HPPA_BASE, default 64'h80000000, host physical address mapped to ATT entry 0.
REQ-003 SHALL have parameter ATT_ENTRY_CNT, default 16, number of valid ATT entries.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports req_valid/req_ready, input/output, 1/1, CPU lookup request handshake.
REQ-007 SHALL have port req_hppa, input, 48, host physical byte address of the request.
REQ-008 SHALL have ports arvalid/arready, output/input, 1/1, AXI read-address handshake.
REQ-009 SHALL have port araddr, output, 64, 64B-aligned ATT block address; arlen=0 and arsize=6 are fixed.
REQ-010 SHALL have ports rvalid/rready/rlast, input/output/input, 1/1/1, AXI read-data handshake.
REQ-011 SHALL have ports rdata/rresp, input/input, 512/2, AXI read data and response.
REQ-012 SHALL have ports out_valid/out_ready, output/input, 1/1, translation result handshake.
REQ-013 SHALL have ports out_ppa/out_sts/out_allow/out_err, output, 48/2/1/1, translation result.

Function
REQ-014 SHALL use FSM states IDLE, AR, R, RESP.
REQ-015 IDLE: req_ready=1; on req_valid&req_ready, register req_hppa and compute idx=(req_hppa-HPPA_BASE)>>12, 64-bit unsigned arithmetic.
REQ-016 If req_hppa<HPPA_BASE or idx>=ATT_ENTRY_CNT, SHALL go IDLE->RESP with out_err=1, out_allow=0, out_sts=0, out_ppa=0, and issue no AXI read.
REQ-017 Otherwise SHALL go IDLE->AR with araddr=(ATT_BASE+idx*8)&~63 and slot=idx[2:0] registered.
REQ-018 AR: arvalid=1, araddr stable until arvalid&arready; then ->R.
REQ-019 R: rready=1; first accepted beat captures entry=rdata[slot*64+:64] and rresp; later beats are accepted and discarded; ->RESP on the beat with rlast=1.
REQ-020 Entry decode: out_sts=entry[1:0], out_ppa=entry[49:2].
REQ-021 out_allow SHALL be 1 only when rresp==0 and out_sts==STS_UNCOMP (2'b01).
REQ-022 rresp!=0 SHALL give out_err=1, out_allow=0, out_sts=0, out_ppa=0.
REQ-023 RESP: out_valid=1, all out_* stable until out_valid&out_ready; then ->IDLE.
REQ-024 req_ready SHALL be 0 outside IDLE; exactly one outstanding lookup.
REQ-025 Minimum latency SHALL be 1 cycle (req accept -> arvalid) and 1 cycle (rlast accept -> out_valid); back-to-back requests allowed the cycle after out handshake.
REQ-026 arvalid, rready, out_valid SHALL be registered outputs, never combinational from same-cycle inputs.
REQ-027 rvalid in states other than R SHALL be ignored (rready=0).

Reset
REQ-028 rst_i=1 SHALL force state IDLE, req_ready=0 while rst_i=1, arvalid=0, rready=0, out_valid=0, araddr=0, out_ppa=0, out_sts=0, out_allow=0, out_err=0.
REQ-029 Reset mid-operation (AR, R, RESP) SHALL abandon the lookup with no output; req_ready=1 the first cycle after rst_i deasserts.

Verification
REQ-030 Hit: hppa=0x80003000, entry slot 3 = 0x...05 (sts=01) -> araddr=0xFFF6100000, out_allow=1, out_sts=1, out_ppa=entry[49:2], out_err=0.
REQ-031 Second block: hppa=0x8000A000 -> araddr=0xFFF6100040, slot 2 selected; sts=10 -> out_allow=0, out_err=0.
REQ-032 Out of range: hppa=0x80010000 (idx 16) and hppa=0x7FFFF000 -> no arvalid, out_err=1, out_allow=0 next cycle.
REQ-033 Error response: rresp=2'b10 -> out_err=1, out_allow=0, out_ppa=0.
REQ-034 Backpressure: arready low 5 cycles, out_ready low 4 cycles -> araddr and out_* stable, req_ready=0 throughout.
REQ-035 Reset in R state with rvalid pending -> no out_valid, rready=0, req_ready=1 the cycle after reset release; next lookup correct.
